// File: rtl/count_4_ctrl_pkg.sv
// Shared types and default sizes for the 4-bit counter run controller.
package count_ctrl_pkg;

    // Default datapath sizes; the top exposes them as overridable parameters.
    localparam int unsigned WIDTH_DEF  = 4;
    localparam int unsigned PCNT_W_DEF = 8;

    // Run-controller states. IDLE is the reset state.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } state_e;

    // Command bundle from the FSM to the counter core.
    typedef struct packed {
        logic clr;  // synchronous clear to zero, wins over en
        logic en;   // increment by one
    } cnt_cmd_t;

endpackage : count_ctrl_pkg

// File: rtl/count_4_ctrl_cnt_core.sv
// WIDTH-bit up-counter register: synchronous clear, count enable and an
// asynchronous active-high reset. No wrap protection here; the controller
// never enables it while the count sits at the terminal value.
module cnt_core
    import count_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  cnt_cmd_t         cmd,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] cnt_q;

    // Next count: clear has priority over increment, otherwise hold.
    always_comb begin
        // NOTE: default assignment first so every path writes cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (cmd.clr) begin
            cnt_d = '0;
        end else if (cmd.en) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Count register with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignment for state so all flops update from pre-edge values.
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule : cnt_core

// File: rtl/count_4_ctrl.sv
// Run controller for one WIDTH-bit up-counter: start / pause / stop
// sequencing, programmable terminal value, one-shot or auto-reload periods,
// a one-cycle done pulse per period and a saturating period tally.
module count_4_ctrl
    import count_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned PCNT_W = PCNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              reload,
    input  logic [WIDTH-1:0]  limit,
    output logic [WIDTH-1:0]  out,
    output logic              busy,
    output logic              done,
    output logic [PCNT_W-1:0] pcnt
);

    localparam logic [PCNT_W-1:0] PCNT_ONE = PCNT_W'(1);
    localparam logic [PCNT_W-1:0] PCNT_MAX = '1;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  lim_q,   lim_d;
    logic              mode_q,  mode_d;
    logic              done_q,  done_d;
    logic              busy_q,  busy_d;
    logic [PCNT_W-1:0] pcnt_q,  pcnt_d;

    cnt_cmd_t          cnt_cmd;
    logic [WIDTH-1:0]  cnt_out;
    logic              terminal;

    cnt_core #(
        .WIDTH (WIDTH)
    ) u_cnt_core (
        .clk   (clk),
        .reset (reset),
        .cmd   (cnt_cmd),
        .q     (cnt_out)
    );

    // The counter only ever climbs to the latched limit, so equality is the
    // terminal test; it can never step past it and wrap.
    assign terminal = (cnt_out == lim_q);

    // Next-state and counter command: stop beats pause beats start/count.
    always_comb begin
        state_d     = state_q;
        lim_d       = lim_q;
        mode_d      = mode_q;
        pcnt_d      = pcnt_q;
        done_d      = 1'b0;
        cnt_cmd.clr = 1'b0;
        cnt_cmd.en  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // start is honoured only here; limit and mode are frozen for the run.
                if (start && !stop) begin
                    state_d     = ST_RUN;
                    cnt_cmd.clr = 1'b1;
                    pcnt_d      = '0;
                    lim_d       = limit;
                    mode_d      = reload;
                end
            end

            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (pause) begin
                    // A terminal count seen while pausing is deferred, not lost.
                    state_d = ST_PAUSED;
                end else if (!terminal) begin
                    cnt_cmd.en = 1'b1;
                end else begin
                    done_d = 1'b1;
                    if (pcnt_q != PCNT_MAX) begin
                        pcnt_d = pcnt_q + PCNT_ONE;
                    end
                    if (mode_q) begin
                        // Auto-reload: next period starts with no idle cycle.
                        cnt_cmd.clr = 1'b1;
                    end else begin
                        // One-shot: out keeps showing the terminal value.
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_PAUSED: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (!pause) begin
                    // Resume; counting restarts on the following edge.
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            lim_q   <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            pcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            lim_q   <= lim_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            pcnt_q  <= pcnt_d;
        end
    end

    assign out  = cnt_out;
    assign busy = busy_q;
    assign done = done_q;
    assign pcnt = pcnt_q;

endmodule : count_4_ctrl

// File: tb/tb_count_4_ctrl.sv
// Self-checking bench for count_4_ctrl: a vector table, hand-written corner
// sequences, and randomized traffic against a behavioural model.
module tb_count_4_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, stop, pause, reload;
    logic [3:0] limit;
    logic [3:0] out;
    logic       busy, done;
    logic [7:0] pcnt;

    int n_cmp  = 0;
    int n_fail = 0;

    count_4_ctrl #(.WIDTH(4), .PCNT_W(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .stop   (stop),
        .pause  (pause),
        .reload (reload),
        .limit  (limit),
        .out    (out),
        .busy   (busy),
        .done   (done),
        .pcnt   (pcnt)
    );

    always #5 clk = ~clk;

    // Behavioural model: running/paused flags plus plain integers.
    bit m_running, m_paused, m_mode, m_done;
    int m_out, m_lim, m_pcnt;

    function automatic void model_reset();
        m_running = 0; m_paused = 0; m_mode = 0; m_done = 0;
        m_out = 0; m_lim = 0; m_pcnt = 0;
    endfunction

    function automatic void model_step(bit s_start, bit s_stop, bit s_pause,
                                       bit s_reload, int s_limit);
        m_done = 0;
        if (!m_running && !m_paused) begin
            if (s_start && !s_stop) begin
                m_running = 1; m_out = 0; m_pcnt = 0;
                m_lim = s_limit; m_mode = s_reload;
            end
        end else if (s_stop) begin
            m_running = 0; m_paused = 0;
        end else if (m_paused) begin
            if (!s_pause) begin m_paused = 0; m_running = 1; end
        end else if (s_pause) begin
            m_paused = 1; m_running = 0;
        end else if (m_out < m_lim) begin
            m_out = m_out + 1;
        end else begin
            m_done = 1;
            m_pcnt = (m_pcnt >= 255) ? 255 : m_pcnt + 1;
            if (m_mode) m_out = 0;
            else        m_running = 0;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock edge; model follows the inputs present at the edge.
    task automatic tick();
        @(posedge clk);
        model_step(start, stop, pause, reload, int'(limit));
        #1;
    endtask

    task automatic drive(input bit s, input bit p, input bit pa, input bit rl, input int lim);
        start = s; stop = p; pause = pa; reload = rl; limit = 4'(lim);
    endtask

    // Asynchronous reset pulse between edges; outputs must clear at once.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        #2;
        model_reset();
        check({tag, "_out"},  32'(out),  32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_pcnt"}, 32'(pcnt), 32'd0);
        reset = 1'b0;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_out"},  32'(out),  32'(m_out));
        check({tag, "_busy"}, 32'(busy), 32'(m_running | m_paused));
        check({tag, "_done"}, 32'(done), 32'(m_done));
        check({tag, "_pcnt"}, 32'(pcnt), 32'(m_pcnt));
    endtask

    typedef struct {
        bit       start, stop, pause, reload;
        bit [3:0] limit;
        bit [3:0] e_out;
        bit       e_busy, e_done;
        bit [7:0] e_pcnt;
    } vec_t;

    vec_t vecs[20];

    initial begin
        drive(0, 0, 0, 0, 0);
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_out",  32'(out),  32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_pcnt", 32'(pcnt), 32'd0);
        reset = 1'b0;

        // ---- Vector table: one-shot limit 5, busy-time start/limit ignored,
        //      start+stop in IDLE, reload limit 3 with pause, then stop.
        //            st sp pa rl lim  out busy done pcnt
        vecs[0]  = '{1, 0, 0, 0, 5,  0, 1, 0, 0};
        vecs[1]  = '{1, 0, 0, 1, 9,  1, 1, 0, 0};
        vecs[2]  = '{0, 0, 0, 1, 2,  2, 1, 0, 0};
        vecs[3]  = '{0, 0, 0, 0, 5,  3, 1, 0, 0};
        vecs[4]  = '{0, 0, 0, 0, 5,  4, 1, 0, 0};
        vecs[5]  = '{0, 0, 0, 0, 5,  5, 1, 0, 0};
        vecs[6]  = '{0, 0, 0, 0, 5,  5, 0, 1, 1};
        vecs[7]  = '{0, 0, 0, 0, 5,  5, 0, 0, 1};
        vecs[8]  = '{1, 1, 0, 1, 3,  5, 0, 0, 1};
        vecs[9]  = '{1, 0, 0, 1, 3,  0, 1, 0, 0};
        vecs[10] = '{0, 0, 0, 0, 7,  1, 1, 0, 0};
        vecs[11] = '{0, 0, 0, 0, 0,  2, 1, 0, 0};
        vecs[12] = '{0, 0, 0, 0, 3,  3, 1, 0, 0};
        vecs[13] = '{1, 0, 0, 0, 3,  0, 1, 1, 1};
        vecs[14] = '{0, 0, 0, 0, 3,  1, 1, 0, 1};
        vecs[15] = '{0, 0, 1, 0, 3,  1, 1, 0, 1};
        vecs[16] = '{0, 0, 1, 0, 3,  1, 1, 0, 1};
        vecs[17] = '{0, 0, 0, 0, 3,  1, 1, 0, 1};
        vecs[18] = '{0, 0, 0, 0, 3,  2, 1, 0, 1};
        vecs[19] = '{0, 1, 0, 0, 3,  2, 0, 0, 1};

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].start, vecs[i].stop, vecs[i].pause, vecs[i].reload, int'(vecs[i].limit));
            tick();
            check($sformatf("vec%0d_out", i),  32'(out),  32'(vecs[i].e_out));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
            check($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].e_done));
            check($sformatf("vec%0d_pcnt", i), 32'(pcnt), 32'(vecs[i].e_pcnt));
        end
        drive(0, 0, 0, 0, 0);

        // ---- Reset mid-run, then a fresh start behaves normally.
        drive(1, 0, 0, 1, 9);
        tick();
        drive(0, 0, 0, 1, 9);
        repeat (5) tick();
        check("rstmid_pre_out", 32'(out), 32'd5);
        do_reset("rstmid");
        drive(1, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 1);
        tick();
        check("rstmid_after_out", 32'(out), 32'd1);
        tick();
        check("rstmid_after_done", 32'(done), 32'd1);
        check("rstmid_after_pcnt", 32'(pcnt), 32'd1);

        // ---- Reload limit 3 for 12 cycles, then stop without extra done.
        do_reset("rst_a");
        drive(1, 0, 0, 1, 3);
        tick();
        drive(0, 0, 0, 1, 3);
        for (int i = 1; i <= 12; i++) begin
            tick();
            check($sformatf("rel_out%0d", i),  32'(out),  32'(i % 4));
            check($sformatf("rel_done%0d", i), 32'(done), 32'((i % 4) == 0));
        end
        check("rel_pcnt", 32'(pcnt), 32'd3);
        drive(0, 1, 0, 1, 3);
        tick();
        check("rel_stop_busy", 32'(busy), 32'd0);
        check("rel_stop_done", 32'(done), 32'd0);
        drive(0, 0, 0, 1, 3);
        repeat (3) tick();
        check("rel_idle_done", 32'(done), 32'd0);
        check("rel_idle_pcnt", 32'(pcnt), 32'd3);

        // ---- Pause while sitting on the terminal value defers done.
        drive(1, 0, 0, 0, 2);
        tick();
        drive(0, 0, 0, 0, 2);
        repeat (2) tick();
        check("pterm_out", 32'(out), 32'd2);
        drive(0, 0, 1, 0, 2);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("pterm_hold_out%0d", i),  32'(out),  32'd2);
            check($sformatf("pterm_hold_done%0d", i), 32'(done), 32'd0);
        end
        drive(0, 0, 0, 0, 2);
        tick();
        check("pterm_resume_done", 32'(done), 32'd0);
        check("pterm_resume_busy", 32'(busy), 32'd1);
        tick();
        check("pterm_done", 32'(done), 32'd1);
        check("pterm_busy", 32'(busy), 32'd0);
        check("pterm_pcnt", 32'(pcnt), 32'd1);

        // ---- limit 0, reload: done every cycle, pcnt saturates at 255.
        drive(1, 0, 0, 1, 0);
        tick();
        drive(0, 0, 0, 1, 0);
        repeat (254) tick();
        check("sat_pcnt254", 32'(pcnt), 32'd254);
        check("sat_done254", 32'(done), 32'd1);
        tick();
        check("sat_pcnt255", 32'(pcnt), 32'd255);
        repeat (20) tick();
        check("sat_pcnt_hold", 32'(pcnt), 32'd255);
        check("sat_done_hold", 32'(done), 32'd1);
        check("sat_out",       32'(out),  32'd0);
        drive(0, 1, 0, 1, 0);
        tick();
        check("sat_stop_done", 32'(done), 32'd0);

        // ---- limit 15 one-shot: reaches 15 and never wraps.
        drive(1, 0, 0, 0, 15);
        tick();
        drive(0, 0, 0, 0, 15);
        repeat (15) tick();
        check("l15_out", 32'(out), 32'd15);
        check("l15_busy", 32'(busy), 32'd1);
        tick();
        check("l15_done", 32'(done), 32'd1);
        check("l15_busy_end", 32'(busy), 32'd0);
        tick();
        check("l15_hold_out", 32'(out), 32'd15);
        check("l15_hold_done", 32'(done), 32'd0);

        // ---- Randomized traffic against the model.
        do_reset("rst_rnd");
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(299) == 0) begin
                do_reset("rnd_rst");
            end
            drive(($urandom_range(3) == 0), ($urandom_range(23) == 0),
                  ($urandom_range(5) == 0), 1'($urandom_range(1)),
                  int'($urandom_range(15) >> ($urandom_range(1) * 2)));
            tick();
            check_model($sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_count_4_ctrl
